// File: rtl/alarm_clock.sv
// 24-hour HH:MM:SS clock with one HH:MM alarm, a 1 s prescaler and BCD
// digit load/display. Binary state is kept internally and decoded to BCD on output.
module alarm_clock #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic       LD_time,
  input  logic       LD_alarm,
  input  logic       STOP_al,
  input  logic       AL_ON,
  output logic       Alarm,
  output logic [1:0] H_out1,
  output logic [3:0] H_out0,
  output logic [3:0] M_out1,
  output logic [3:0] M_out0,
  output logic [3:0] S_out1,
  output logic [3:0] S_out0
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  logic [4:0]    hour_q, hour_d, al_h_q, al_h_d;
  logic [5:0]    min_q, min_d, sec_q, sec_d, al_m_q, al_m_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          alarm_q, alarm_d;
  logic          tick;
  logic [5:0]    h_raw;
  logic [7:0]    m_raw;
  logic [4:0]    ld_hour;
  logic [5:0]    ld_min;

  // Digit inputs converted to binary; out-of-range values clamp to 23 / 59.
  always_comb begin
    h_raw   = {4'b0, H_in1} * 6'd10 + {2'b0, H_in0};
    m_raw   = {4'b0, M_in1} * 8'd10 + {4'b0, M_in0};
    ld_hour = (h_raw > 6'd23) ? 5'd23 : h_raw[4:0];
    ld_min  = (m_raw > 8'd59) ? 6'd59 : m_raw[5:0];
  end

  always_comb begin
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pre_d   = pre_q;
    al_h_d  = al_h_q;
    al_m_d  = al_m_q;
    alarm_d = alarm_q;
    tick    = 1'b0;
    if (LD_alarm) begin
      al_h_d = ld_hour;
      al_m_d = ld_min;
    end
    if (LD_time) begin
      hour_d = ld_hour;
      min_d  = ld_min;
      sec_d  = 6'd0;
      pre_d  = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      tick  = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end
    // Only a counted second can trigger the alarm, never a time load.
    if (tick && AL_ON && hour_d == al_h_q && min_d == al_m_q && sec_d == 6'd0)
      alarm_d = 1'b1;
    if (STOP_al)
      alarm_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hour_q  <= ld_hour;
      min_q   <= ld_min;
      sec_q   <= 6'd0;
      pre_q   <= '0;
      al_h_q  <= 5'd0;
      al_m_q  <= 6'd0;
      alarm_q <= 1'b0;
    end else begin
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pre_q   <= pre_d;
      al_h_q  <= al_h_d;
      al_m_q  <= al_m_d;
      alarm_q <= alarm_d;
    end
  end

  assign Alarm  = alarm_q;
  assign H_out1 = 2'(hour_q / 5'd10);
  assign H_out0 = 4'(hour_q % 5'd10);
  assign M_out1 = 4'(min_q / 6'd10);
  assign M_out0 = 4'(min_q % 6'd10);
  assign S_out1 = 4'(sec_q / 6'd10);
  assign S_out0 = 4'(sec_q % 6'd10);

endmodule

// File: tb/tb_alarm_clock.sv
// Bench for alarm_clock: directed scenarios plus a randomized phase, all
// compared cycle by cycle against a seconds-of-day reference model.
module tb_alarm_clock;

  localparam int TPS = 10;

  logic       clk;
  logic       reset;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON;
  logic       Alarm;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time as seconds since midnight, alarm as minute of day.
  int t_s, pre_m, al_min;
  bit alarm_m;

  alarm_clock #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .Alarm(Alarm), .H_out1(H_out1), .H_out0(H_out0),
    .M_out1(M_out1), .M_out0(M_out0), .S_out1(S_out1), .S_out0(S_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] vec(input int al, input int h, input int m, input int s);
    return {al[0], 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [22:0] obs();
    return {Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
  endfunction

  task automatic chk(input string tag, input logic [22:0] exp);
    logic [22:0] o;
    o = obs();
    n_cmp++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  task automatic model_edge();
    int lh, lm, al_old;
    lh = int'(H_in1) * 10 + int'(H_in0);
    lm = int'(M_in1) * 10 + int'(M_in0);
    if (lh > 23) lh = 23;
    if (lm > 59) lm = 59;
    al_old = al_min;
    if (reset) begin
      t_s = lh * 3600 + lm * 60; pre_m = 0; al_min = 0; alarm_m = 0;
    end else begin
      if (LD_alarm) al_min = lh * 60 + lm;
      if (LD_time) begin
        t_s = lh * 3600 + lm * 60; pre_m = 0;
      end else if (pre_m == TPS - 1) begin
        pre_m = 0;
        t_s = (t_s + 1) % 86400;
        if (AL_ON && t_s == al_old * 60) alarm_m = 1;
      end else begin
        pre_m++;
      end
      if (STOP_al) alarm_m = 0;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      chk("model", vec(int'(alarm_m), t_s / 3600, (t_s / 60) % 60, t_s % 60));
    end
  endtask

  task automatic set_hm(input int h, input int m);
    H_in1 = 2'(h / 10); H_in0 = 4'(h % 10);
    M_in1 = 4'(m / 10); M_in0 = 4'(m % 10);
  endtask

  initial begin
    reset = 1'b1; LD_time = 1'b0; LD_alarm = 1'b0; STOP_al = 1'b0; AL_ON = 1'b0;
    t_s = 0; pre_m = 0; al_min = 0; alarm_m = 0;
    set_hm(10, 14);
    @(negedge clk);
    step(3);
    chk("reset_state", vec(0, 10, 14, 0));

    reset = 1'b0; LD_alarm = 1'b1; AL_ON = 1'b1; set_hm(10, 20);
    step(1);
    LD_alarm = 1'b0; set_hm(7, 7);
    step(9);
    chk("first_second", vec(0, 10, 14, 1));
    step(3589);
    chk("pre_alarm", vec(0, 10, 19, 59));
    step(1);
    chk("alarm_rise", vec(1, 10, 20, 0));
    step(5);
    chk("alarm_sticky", vec(1, 10, 20, 0));

    STOP_al = 1'b1;
    step(10);
    STOP_al = 1'b0;
    chk("stop_clears", vec(0, 10, 20, 1));
    step(580);
    chk("stop_rest_min", vec(0, 10, 20, 59));

    LD_time = 1'b1; LD_alarm = 1'b1; set_hm(4, 45);
    step(1);
    chk("ld_time", vec(0, 4, 45, 0));
    LD_time = 1'b0; set_hm(4, 55);
    step(1);
    LD_alarm = 1'b0;
    step(5998);
    chk("pre_alarm2", vec(0, 4, 54, 59));
    step(1);
    chk("alarm_rise2", vec(1, 4, 55, 0));

    LD_time = 1'b1; STOP_al = 1'b1; set_hm(23, 59);
    step(1);
    LD_time = 1'b0; STOP_al = 1'b0;
    chk("load_2359", vec(0, 23, 59, 0));
    step(600);
    chk("midnight", vec(0, 0, 0, 0));
    LD_time = 1'b1; set_hm(9, 59);
    step(1);
    LD_time = 1'b0;
    step(600);
    chk("hour_carry", vec(0, 10, 0, 0));

    AL_ON = 1'b0; LD_alarm = 1'b1; set_hm(10, 1);
    step(1);
    LD_alarm = 1'b0;
    step(599);
    chk("al_off_match", vec(0, 10, 1, 0));
    AL_ON = 1'b1; LD_alarm = 1'b1; set_hm(10, 2);
    step(1);
    LD_alarm = 1'b0;
    step(598);
    STOP_al = 1'b1;
    step(1);
    STOP_al = 1'b0;
    chk("stop_vs_set", vec(0, 10, 2, 0));

    LD_time = 1'b1; H_in1 = 2'd3; H_in0 = 4'd9; M_in1 = 4'd9; M_in0 = 4'd9;
    step(1);
    LD_time = 1'b0;
    chk("saturate", vec(0, 23, 59, 0));

    // Randomized phase; alarms are often aimed a minute or two ahead so matches occur.
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      LD_time  = ($urandom_range(0, 199) == 0);
      LD_alarm = ($urandom_range(0, 99) == 0);
      STOP_al  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) AL_ON = ~AL_ON;
      if (LD_alarm && $urandom_range(0, 1) == 1) begin
        int tm;
        tm = (t_s / 60 + int'($urandom_range(1, 2))) % 1440;
        set_hm(tm / 60, tm % 60);
      end else begin
        H_in1 = 2'($urandom); H_in0 = 4'($urandom);
        M_in1 = 4'($urandom); M_in0 = 4'($urandom);
      end
      if (LD_time && $urandom_range(0, 1) == 1) begin
        H_in1 = 2'($urandom_range(0, 2)); H_in0 = 4'($urandom_range(0, 9));
        M_in1 = 4'($urandom_range(0, 5)); M_in0 = 4'($urandom_range(0, 8));
      end
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
